pipeline_hazard_ctrl: RTL

Central stall/flush sequencer for the 5-stage pipeline. It detects load-use hazards in ID, control redirects resolved in EX, and multi-cycle data-memory accesses in MEM. It drives the hold and flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also keeps saturating stall and flush performance counters and a sticky memory-timeout error.

---
 rtl/ctrl_pkg.sv | 13 +
 rtl/sat_counter.sv | 30 +++
 rtl/pipeline_hazard_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types and defaults for the pipeline hazard controller
package ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  localparam int DEF_MEM_TIMEOUT = 64;
  localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous active-high clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
// Control outputs are combinational; the pipeline registers sample them on the same edge.
module pipeline_hazard_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IF_ID_Rs1,
  input  logic [4:0]       IF_ID_Rs2,
  input  logic             Uses_Rs1,
  input  logic             Uses_Rs2,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_Rd,
  input  logic             EX_Redirect,
  input  logic             EX_MEM_MemRead,
  input  logic             EX_MEM_MemWrite,
  input  logic             dmem_ready,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             Control_Sig_Stall,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Hold,
  output logic             MEM_WB_Bubble,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
  logic              mem_pending;
  logic              load_use;
  logic              flush_inc;
  logic              stall_inc;

  assign mem_pending = (EX_MEM_MemRead | EX_MEM_MemWrite) & ~dmem_ready;

  assign load_use = ID_EX_MemRead & (ID_EX_Rd != 5'd0) &
                    ((Uses_Rs1 & (IF_ID_Rs1 == ID_EX_Rd)) |
                     (Uses_Rs2 & (IF_ID_Rs2 == ID_EX_Rd)));

  // A frozen ID/EX keeps redirect/load-use asserted, so they resolve after release.
  always_comb begin
    PC_Write          = 1'b1;
    IF_ID_Write       = 1'b1;
    IF_ID_Flush       = 1'b0;
    Control_Sig_Stall = 1'b0;
    ID_EX_Flush       = 1'b0;
    EX_MEM_Hold       = 1'b0;
    MEM_WB_Bubble     = 1'b0;
    flush_inc         = 1'b0;
    if (reset) begin
      PC_Write      = 1'b0;
      IF_ID_Write   = 1'b0;
      IF_ID_Flush   = 1'b1;
      ID_EX_Flush   = 1'b1;
      MEM_WB_Bubble = 1'b1;
    end else if ((state_q == ERROR) || mem_pending) begin
      PC_Write          = 1'b0;
      IF_ID_Write       = 1'b0;
      Control_Sig_Stall = 1'b1;
      EX_MEM_Hold       = 1'b1;
      MEM_WB_Bubble     = 1'b1;
    end else if (EX_Redirect) begin
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
      flush_inc   = 1'b1;
    end else if (load_use) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    case (state_q)
      RUN: begin
        if (mem_pending) begin
          state_d = MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!mem_pending) begin
          state_d = RUN;
          wait_d  = '0;
        end else if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
          state_d = ERROR;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  assign stall_inc       = ~PC_Write & ~reset;
  assign mem_timeout_err = err_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule
